// File: rtl/fpu_wb_master.sv
// fpu_wb_master: turns one FPU command into a Wishbone classic sequence
// (write op_a, write op_b, write ctrl/opcode, read result) and returns the
// result through a valid/ready response port.
//
// Ports:
//   wb_clk_i, wb_rst_i              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_op_a, cmd_op_b, cmd_opcode  operands and FPU opcode
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_err               result word and error flag
//   wbm_*_o / wbm_dat_i, wbm_ack_i  Wishbone classic initiator
//   busy                            high whenever the FSM is not IDLE
//
// Optional feature: define WB_TIMEOUT_EN to bound each bus wait by
// TIMEOUT_CYCLES; on expiry the command completes with rsp_err=1, rsp_data=0.
// Without the macro every bus state waits for ack indefinitely.
module fpu_wb_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_op_a,
  input  logic [31:0] cmd_op_b,
  input  logic [3:0]  cmd_opcode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam logic [31:0] OFS_A    = 32'h0000_0000;
  localparam logic [31:0] OFS_B    = 32'h0000_0004;
  localparam logic [31:0] OFS_CTRL = 32'h0000_0008;
  localparam logic [31:0] OFS_RES  = 32'h0000_000C;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_A    = 3'd1,
    WR_B    = 3'd2,
    WR_CTRL = 3'd3,
    RD_RES  = 3'd4,
    GAP     = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t      state, state_d;
  state_t      after_gap, after_gap_d;   // bus state to resume after GAP
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [31:0] rsp_data_d;

  logic        cmd_ready_d, rsp_valid_d, busy_d;
  logic        cyc_d, stb_d, we_d;
  logic [3:0]  sel_d;
  logic [31:0] adr_d, dat_d;

  logic        in_bus;
  logic        tmo_hit;

  assign in_bus = (state == WR_A) || (state == WR_B) ||
                  (state == WR_CTRL) || (state == RD_RES);

`ifdef WB_TIMEOUT_EN
  // Counter holds cycles spent without ack in the current bus state; the
  // edge at which it would reach TIMEOUT_CYCLES is the expiry edge.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;
  logic             rsp_err_d;

  assign tmo_hit = in_bus && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= '0;
    end else if (state_d != state) begin
      tmo_cnt <= '0;
    end else if (in_bus) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Ack wins over an expiry in the same cycle.
  always_comb begin
    rsp_err_d = rsp_err;
    if (state == RD_RES && wbm_ack_i) begin
      rsp_err_d = 1'b0;
    end else if (tmo_hit && !wbm_ack_i) begin
      rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) rsp_err <= 1'b0;
    else          rsp_err <= rsp_err_d;
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign rsp_err        = 1'b0;
  assign unused_tmo_cfg = ^(32'(TIMEOUT_CYCLES));
`endif

  // Next state, operand latching and result capture.
  always_comb begin
    state_d     = state;
    after_gap_d = after_gap;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opcode_d    = opcode_q;
    rsp_data_d  = rsp_data;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_a_d   = cmd_op_a;
          op_b_d   = cmd_op_b;
          opcode_d = cmd_opcode;
          state_d  = WR_A;
        end
      end
      WR_A, WR_B, WR_CTRL, RD_RES: begin
        if (wbm_ack_i) begin
          case (state)
            WR_A:    begin state_d = GAP; after_gap_d = WR_B;    end
            WR_B:    begin state_d = GAP; after_gap_d = WR_CTRL; end
            WR_CTRL: begin state_d = GAP; after_gap_d = RD_RES;  end
            default: begin state_d = RESP; rsp_data_d = wbm_dat_i; end
          endcase
        end else if (tmo_hit) begin
          state_d    = RESP;
          rsp_data_d = 32'h0;
        end
      end
      GAP: begin
        state_d = after_gap;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    cyc_d       = 1'b0;
    stb_d       = 1'b0;
    we_d        = 1'b0;
    sel_d       = 4'h0;
    adr_d       = 32'h0;
    dat_d       = 32'h0;
    busy_d      = (state_d != IDLE);

    case (state_d)
      IDLE: cmd_ready_d = 1'b1;
      WR_A: begin
        cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1; sel_d = 4'hF;
        adr_d = BASE_ADDR + OFS_A;
        dat_d = op_a_d;
      end
      WR_B: begin
        cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1; sel_d = 4'hF;
        adr_d = BASE_ADDR + OFS_B;
        dat_d = op_b_d;
      end
      WR_CTRL: begin
        cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1; sel_d = 4'hF;
        adr_d = BASE_ADDR + OFS_CTRL;
        dat_d = {28'h0, opcode_d};
      end
      RD_RES: begin
        cyc_d = 1'b1; stb_d = 1'b1; sel_d = 4'hF;
        adr_d = BASE_ADDR + OFS_RES;
      end
      RESP: rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      after_gap <= WR_A;
      op_a_q    <= 32'h0;
      op_b_q    <= 32'h0;
      opcode_q  <= 4'h0;
      rsp_data  <= 32'h0;
      rsp_valid <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
    end else begin
      state     <= state_d;
      after_gap <= after_gap_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      opcode_q  <= opcode_d;
      rsp_data  <= rsp_data_d;
      rsp_valid <= rsp_valid_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= stb_d;
      wbm_we_o  <= we_d;
      wbm_sel_o <= sel_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
    end
  end

endmodule
